// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator: pixel/line counters, sync and blank decode
// delayed PIPE cycles to match BROM read latency, plus line/frame ticks and a frame counter.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE     = 1,
  parameter int CNT_W    = 11,
  parameter int FRAME_W  = 16
) (
  input  logic               clk_65M,
  input  logic               clear_n,
  input  logic               en,
  output logic [CNT_W-1:0]   H_cnt,
  output logic [CNT_W-1:0]   V_cnt,
  output logic               H_sync,
  output logic               V_sync,
  output logic               Vid_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } decode_t;

  logic    h_last;
  logic    v_last;
  decode_t dec;
  decode_t dly;

  assign h_last = (H_cnt == H_LAST);
  assign v_last = (V_cnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let V_cnt see the already-wrapped H_cnt.
  always_ff @(posedge clk_65M or negedge clear_n) begin
    if (!clear_n) begin
      H_cnt       <= '0;
      V_cnt       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= en && h_last;
      frame_start <= en && h_last && v_last;
      if (en) begin
        H_cnt <= h_last ? '0 : H_cnt + 1'b1;
        if (h_last) begin
          V_cnt <= v_last ? '0 : V_cnt + 1'b1;
          if (v_last) frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign dec.act = (H_cnt < H_ACT_END) && (V_cnt < V_ACT_END);
  assign dec.hs  = (H_cnt >= H_SYNC_LO) && (H_cnt <= H_SYNC_HI);
  assign dec.vs  = (V_cnt >= V_SYNC_LO) && (V_cnt <= V_SYNC_HI);

  // Delay line runs every clock regardless of en, matching the fixed BROM latency.
  if (PIPE == 0) begin : g_no_pipe
    assign dly = dec;
  end else begin : g_pipe
    decode_t [PIPE-1:0] pipe_q;

    // NOTE: every delay stage is reset to the inactive pattern so no stale sync or
    // video pulse escapes in the first PIPE cycles after reset.
    always_ff @(posedge clk_65M or negedge clear_n) begin
      if (!clear_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= dec;
        for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign dly = pipe_q[PIPE-1];
  end

  assign Vid_on = dly.act;
  assign H_sync = dly.hs ? H_POL : !H_POL;
  assign V_sync = dly.vs ? V_POL : !V_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size XGA instance and a tiny-mode instance, both compared
// every cycle against an arithmetic model driven by the count of enabled clock edges.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int B_HA = 1024, B_HF = 24, B_HS = 136, B_HB = 160;
  localparam int B_VA = 768,  B_VF = 3,  B_VS = 6,   B_VB = 29;
  localparam int B_PIPE = 1, B_CW = 11, B_FW = 16;
  localparam int S_HA = 8, S_HF = 1, S_HS = 2, S_HB = 1;
  localparam int S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 1;
  localparam int S_PIPE = 2, S_CW = 4, S_FW = 2;
  localparam longint B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam longint B_VT = B_VA + B_VF + B_VS + B_VB;
  localparam longint S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam longint S_VT = S_VA + S_VF + S_VS + S_VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_big_n, en_big, rst_small_n, en_small;
  logic [B_CW-1:0]   big_h, big_v;
  logic [B_FW-1:0]   big_f;
  logic              big_hs, big_vs, big_vid, big_ls, big_fs;
  logic [S_CW-1:0]   small_h, small_v;
  logic [S_FW-1:0]   small_f;
  logic              small_hs, small_vs, small_vid, small_ls, small_fs;

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE(B_PIPE), .CNT_W(B_CW), .FRAME_W(B_FW)
  ) u_big (
    .clk_65M(clk), .clear_n(rst_big_n), .en(en_big),
    .H_cnt(big_h), .V_cnt(big_v), .H_sync(big_hs), .V_sync(big_vs), .Vid_on(big_vid),
    .line_start(big_ls), .frame_start(big_fs), .frame_cnt(big_f)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE(S_PIPE), .CNT_W(S_CW), .FRAME_W(S_FW)
  ) u_small (
    .clk_65M(clk), .clear_n(rst_small_n), .en(en_small),
    .H_cnt(small_h), .V_cnt(small_v), .H_sync(small_hs), .V_sync(small_vs), .Vid_on(small_vid),
    .line_start(small_ls), .frame_start(small_fs), .frame_cnt(small_f)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_reset(input string tag, input logic [63:0] h, v, f,
                             input logic ls, fs, vid, hs, vs);
    check({tag, "_hcnt"}, h, 0);
    check({tag, "_vcnt"}, v, 0);
    check({tag, "_frame"}, f, 0);
    check({tag, "_line_start"}, 64'(ls), 0);
    check({tag, "_frame_start"}, 64'(fs), 0);
    check({tag, "_vid_on"}, 64'(vid), 0);
    check({tag, "_hsync"}, 64'(hs), 1);
    check({tag, "_vsync"}, 64'(vs), 1);
  endtask

  // Returns {active, hsync_asserted, vsync_asserted} for the raster position reached
  // after n enabled pixel clocks.
  function automatic logic [2:0] raster_decode(input longint n, input int ha, hf, hsw, hb,
                                               input int va, vf, vsw, vb);
    longint ht, vt, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    raster_decode[2] = (h < ha) && (v < va);
    raster_decode[1] = (h >= ha + hf) && (h < ha + hf + hsw);
    raster_decode[0] = (v >= va + vf) && (v < va + vf + vsw);
  endfunction

  // Model state: enabled-edge count since reset, the last PIPE+1 counts, and tick flags.
  longint b_n, s_n;
  longint b_q[$];
  longint s_q[$];
  bit     b_ls, b_fs, s_ls, s_fs;

  always @(posedge clk or negedge rst_big_n) begin
    if (!rst_big_n) begin
      b_n = 0; b_q.delete(); b_q.push_back(0); b_ls = 0; b_fs = 0;
    end else begin
      b_ls = 0; b_fs = 0;
      if (en_big) begin
        b_n++;
        b_ls = (b_n % B_HT) == 0;
        b_fs = (b_n % (B_HT * B_VT)) == 0;
      end
      b_q.push_back(b_n);
      if (b_q.size() > B_PIPE + 1) void'(b_q.pop_front());
    end
  end

  always @(posedge clk or negedge rst_small_n) begin
    if (!rst_small_n) begin
      s_n = 0; s_q.delete(); s_q.push_back(0); s_ls = 0; s_fs = 0;
    end else begin
      s_ls = 0; s_fs = 0;
      if (en_small) begin
        s_n++;
        s_ls = (s_n % S_HT) == 0;
        s_fs = (s_n % (S_HT * S_VT)) == 0;
      end
      s_q.push_back(s_n);
      if (s_q.size() > S_PIPE + 1) void'(s_q.pop_front());
    end
  end

  task automatic compare(input string tag, input longint n, input longint dn, input bit d_valid,
                         input bit ls, fs, input int ha, hf, hsw, hb, va, vf, vsw, vb, fw,
                         input logic [63:0] a_h, a_v, a_f,
                         input logic a_ls, a_fs, a_vid, a_hs, a_vs);
    longint     ht, vt;
    logic [2:0] d;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    d  = d_valid ? raster_decode(dn, ha, hf, hsw, hb, va, vf, vsw, vb) : 3'b000;
    check({tag, "_hcnt"}, a_h, n % ht);
    check({tag, "_vcnt"}, a_v, (n / ht) % vt);
    check({tag, "_frame_cnt"}, a_f, (n / (ht * vt)) % (64'd1 << fw));
    check({tag, "_line_start"}, 64'(a_ls), 64'(ls));
    check({tag, "_frame_start"}, 64'(a_fs), 64'(fs));
    check({tag, "_vid_on"}, 64'(a_vid), 64'(d[2]));
    check({tag, "_hsync"}, 64'(a_hs), 64'(!d[1]));
    check({tag, "_vsync"}, 64'(a_vs), 64'(!d[0]));
  endtask

  always @(negedge clk) begin
    if (rst_big_n)
      compare("big", b_n, b_q[0], b_q.size() == B_PIPE + 1, b_ls, b_fs,
              B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_FW,
              64'(big_h), 64'(big_v), 64'(big_f), big_ls, big_fs, big_vid, big_hs, big_vs);
    if (rst_small_n)
      compare("small", s_n, s_q[0], s_q.size() == S_PIPE + 1, s_ls, s_fs,
              S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_FW,
              64'(small_h), 64'(small_v), 64'(small_f), small_ls, small_fs, small_vid,
              small_hs, small_vs);
  end

  task automatic big_seq();
    int found, hs_lo, vid_hi, period;
    rst_big_n = 1'b0;
    en_big    = 1'b0;
    #3;
    check_reset("big_por", 64'(big_h), 64'(big_v), 64'(big_f),
                big_ls, big_fs, big_vid, big_hs, big_vs);
    @(negedge clk);
    rst_big_n = 1'b1;
    en_big    = 1'b1;
    repeat (100) @(negedge clk);
    check("big_h_at_100", 64'(big_h), 100);
    en_big = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("big_hold_hcnt", 64'(big_h), 100);
      check("big_hold_line_start", 64'(big_ls), 0);
    end
    en_big = 1'b1;
    repeat (400) @(negedge clk);
    check("big_h_at_500", 64'(big_h), 500);

    // Asynchronous reset pulse mid-line, fully inside one clock period.
    @(posedge clk);
    #1 rst_big_n = 1'b0;
    #2 check_reset("big_async", 64'(big_h), 64'(big_v), 64'(big_f),
                   big_ls, big_fs, big_vid, big_hs, big_vs);
    #1 rst_big_n = 1'b1;
    @(posedge clk);
    #1 check("big_first_edge_hcnt", 64'(big_h), 1);

    found = 0;
    for (int i = 0; i < 1500 && found == 0; i++) begin
      @(negedge clk);
      if (big_hs === 1'b0) found = 1;
    end
    check("big_hsync_fall_seen", 64'(found), 1);
    check("big_hsync_fall_hcnt", 64'(big_h), 1049);
    hs_lo  = 0;
    vid_hi = 0;
    repeat (1344) begin
      @(negedge clk);
      hs_lo  += int'(!big_hs);
      vid_hi += int'(big_vid);
    end
    check("big_hsync_low_clocks", 64'(hs_lo), 136);
    check("big_vid_on_clocks", 64'(vid_hi), 1024);

    // Enable toggling every clock halves the pixel rate.
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      en_big = !en_big;
      if (big_ls) found = 1;
    end
    check("big_toggle_first_tick", 64'(found), 1);
    found  = 0;
    period = 0;
    for (int i = 0; i < 6000 && found == 0; i++) begin
      @(negedge clk);
      en_big = !en_big;
      period++;
      if (big_ls) found = 1;
    end
    check("big_toggle_line_period", 64'(period), 2688);
    en_big = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic small_seq();
    int         fs_seen, found;
    logic [1:0] prev_f;
    rst_small_n = 1'b0;
    en_small    = 1'b0;
    #3;
    check_reset("small_por", 64'(small_h), 64'(small_v), 64'(small_f),
                small_ls, small_fs, small_vid, small_hs, small_vs);
    @(negedge clk);
    rst_small_n = 1'b1;
    @(negedge clk);
    check("small_pipe_vid_c1", 64'(small_vid), 0);
    @(negedge clk);
    check("small_pipe_vid_c2", 64'(small_vid), 1);

    fs_seen = 0;
    for (int i = 0; i < 2000 && fs_seen < 4; i++) begin
      @(negedge clk);
      if (small_fs) fs_seen++;
      en_small = 1'($urandom_range(0, 1));
    end
    check("small_four_frames", 64'(fs_seen), 4);
    check("small_frame_cnt_wrapped", 64'(small_f), 0);
    repeat (200) begin
      @(negedge clk);
      en_small = 1'($urandom_range(0, 1));
    end

    // Hold at the last raster position with en low, then wrap.
    en_small = 1'b1;
    found    = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (small_h == 4'd11 && small_v == 4'd6) found = 1;
    end
    check("small_reach_last", 64'(found), 1);
    en_small = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("small_hold_h", 64'(small_h), 11);
      check("small_hold_v", 64'(small_v), 6);
      check("small_hold_ticks", 64'({small_ls, small_fs}), 0);
    end
    prev_f   = small_f;
    en_small = 1'b1;
    @(negedge clk);
    check("small_wrap_h", 64'(small_h), 0);
    check("small_wrap_v", 64'(small_v), 0);
    check("small_wrap_ticks", 64'({small_ls, small_fs}), 3);
    check("small_wrap_frame", 64'(small_f), 64'(2'(prev_f + 2'd1)));
    @(negedge clk);
    check("small_tick_width", 64'({small_ls, small_fs}), 0);
    check("small_after_wrap_h", 64'(small_h), 1);

    // Reset in the middle of a frame while frame_cnt reads 2.
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (small_f == 2'd2 && small_v == 4'd2) found = 1;
      else en_small = 1'($urandom_range(0, 1));
    end
    check("small_reach_frame2", 64'(found), 1);
    @(posedge clk);
    #1 rst_small_n = 1'b0;
    #2 check_reset("small_async", 64'(small_h), 64'(small_v), 64'(small_f),
                   small_ls, small_fs, small_vid, small_hs, small_vs);
    #1 rst_small_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      en_small = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      big_seq();
      small_seq();
    join
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
